wb_master_arbiter: RTL and testbench
====================================

# wb_master_arbiter

Round-robin arbiter that shares one Wishbone master port between M requesting masters, such as JTAG-to-Wishbone bridges and a processor data port. Each requester connects to its own slave-side port. The arbiter grants one requester at a time, holds the grant for the full bus cycle (cyc high), and forwards that requester's signals to the single master-side port. A per-cycle ack timeout aborts transactions to unresponsive slaves, so a hung access cannot lock out the debug path.

## Interface
- M, 2: number of requesters (2..8)
- DW, 32: data width
- M_Aw, 32: address width
- SELw, 4: byte-select width
- TAGw, 3: cti width
- TOw, 8: timeout counter width; timeout fires after 2^TOw-1 cycles without ack
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_sel_i  in  M*SELw  per-requester byte selects; requester k occupies slice [k*SELw +: SELw] (same slicing for all flattened buses)
- s_dat_i  in  M*DW  per-requester write data
- s_addr_i  in  M*M_Aw  per-requester address
- s_cti_i  in  M*TAGw  per-requester cti
- s_stb_i, s_cyc_i, s_we_i  in  M each  per-requester strobe, cycle, write enable
- s_dat_o  out  DW  read data, broadcast to all requesters (= m_dat_i)
- s_ack_o  out  M  ack, routed to the granted requester only
- s_err_o  out  M  timeout error pulse, granted requester only
- m_sel_o, m_dat_o, m_addr_o, m_cti_o  out  SELw/DW/M_Aw/TAGw  forwarded from the granted requester
- m_stb_o, m_cyc_o, m_we_o  out  1 each  forwarded bus controls
- m_dat_i  in  DW  bus read data
- m_ack_i  in  1  bus acknowledge
- grant_o  out  M  one-hot current grant; zero when no grant is held
- busy_o  out  1  high in the GRANT and ABORT states

## Operation
- States: IDLE, GRANT, ABORT. Reset enters IDLE.
- Pointer register `last` holds the index of the last granted requester. Reset value is M-1, so requester 0 has top priority first.
- IDLE:
  - req = s_cyc_i. If req is nonzero, pick the first set bit scanning `last`+1, `last`+2, …, wrapping modulo M.
  - Register the pick into grant_o and `last`, then go to GRANT.
  - All m_* outputs are 0 in IDLE.
- GRANT:
  - m_sel/dat/addr/cti/stb/cyc/we equal the granted requester's inputs, combinationally.
  - s_ack_o[g] = m_ack_i. All other ack bits are 0.
  - Exit when s_cyc_i[g] falls. On exit, go to IDLE and clear grant_o. The grant therefore spans multi-beat cycles and locked read-modify-write sequences.
  - Timeout counter:
    - Cleared on entering GRANT, on m_ack_i, and whenever m_stb_o is low.
    - Increments each cycle while m_stb_o=1 and m_ack_i=0.
    - When it reaches all-ones without an ack: assert s_err_o[g] for exactly one cycle, then go to ABORT.
- ABORT:
  - m_cyc_o, m_stb_o, and m_we_o are forced to 0. s_ack_o is 0.
  - Wait until s_cyc_i[g]=0, then go to IDLE and clear grant_o.
- A late m_ack_i arriving in ABORT or IDLE is ignored and never forwarded.
- Requests from non-granted requesters are held off (their ack stays 0) until the grant returns to IDLE.
- Reset mid-cycle: all state, grant_o, `last`, and the counter return to reset values immediately. Every output goes to 0 asynchronously.

## Timing
- Reset values: grant_o=0, busy_o=0, and all m_* outputs, s_ack_o, s_err_o = 0.
- Arbitration latency: s_cyc_i rising in IDLE at edge n gives grant_o and forwarded m_cyc_o at edge n+1, i.e. 1 cycle.
- Release: s_cyc_i[g] falling at edge n gives IDLE and grant_o=0 at edge n+1. The next requester's m_cyc_o follows at edge n+2, leaving a minimum of one idle bus cycle between grants.
- Ack and data path is combinational, with zero added latency.
- Error pulse: s_err_o[g] is high for exactly one cycle, in the cycle that leaves GRANT.
- Counter arithmetic: unsigned, TOw bits, saturating at all-ones. No wrap-around.

## Test plan
- Single requester: M=2, requester 1 writes 0xDEADBEEF to 0x10, slave acks 3 cycles after stb.
  - m_addr_o=0x10 and m_dat_o=0xDEADBEEF one cycle after cyc.
  - s_ack_o=2'b10 for one cycle.
  - grant_o returns to 0 one cycle after s_cyc_i[1] falls.
- Round-robin fairness: both requesters hold cyc continuously, each releasing after every acked access.
  - Grants alternate 0,1,0,1 starting with 0 after reset.
  - At least one idle cycle separates consecutive grants.
- Locked cycle: requester 0 performs 4 reads with cyc held high while requester 1 requests.
  - grant_o stays 2'b01 for all 4 acks.
  - Requester 1 is granted only after cyc0 falls.
- Timeout: TOw=4, slave never acks.
  - s_err_o[g] pulses after 15 stb cycles, and m_cyc_o drops in the same edge.
  - A late m_ack_i is not seen on s_ack_o.
  - IDLE is reached only after the requester drops cyc.
- Reset mid-transaction: assert reset while in GRANT with stb high.
  - All outputs are 0 immediately.
  - After release, requester 0 wins a simultaneous request from requesters 0 and 1.
- M=4 wrap: with `last`=3 and requests 4'b1010, requester 1 is granted. Next, with requests 4'b1000, requester 3 is granted.

Source files
------------

// File: rtl/wb_master_arbiter_if.sv
// Bus bundle for wb_master_arbiter: flattened per-requester slave ports plus the shared
// Wishbone master port, grant and busy status.
interface wb_master_arbiter_if #(
  parameter int unsigned M    = 2,
  parameter int unsigned DW   = 32,
  parameter int unsigned M_Aw = 32,
  parameter int unsigned SELw = 4,
  parameter int unsigned TAGw = 3
);
  logic [M*SELw-1:0] s_sel_i;
  logic [M*DW-1:0]   s_dat_i;
  logic [M*M_Aw-1:0] s_addr_i;
  logic [M*TAGw-1:0] s_cti_i;
  logic [M-1:0]      s_stb_i;
  logic [M-1:0]      s_cyc_i;
  logic [M-1:0]      s_we_i;
  logic [DW-1:0]     s_dat_o;
  logic [M-1:0]      s_ack_o;
  logic [M-1:0]      s_err_o;

  logic [SELw-1:0]   m_sel_o;
  logic [DW-1:0]     m_dat_o;
  logic [M_Aw-1:0]   m_addr_o;
  logic [TAGw-1:0]   m_cti_o;
  logic              m_stb_o;
  logic              m_cyc_o;
  logic              m_we_o;
  logic [DW-1:0]     m_dat_i;
  logic              m_ack_i;

  logic [M-1:0]      grant_o;
  logic              busy_o;

  // Arbiter view.
  modport slave (
    input  s_sel_i, s_dat_i, s_addr_i, s_cti_i, s_stb_i, s_cyc_i, s_we_i, m_dat_i, m_ack_i,
    output s_dat_o, s_ack_o, s_err_o, m_sel_o, m_dat_o, m_addr_o, m_cti_o, m_stb_o, m_cyc_o,
           m_we_o, grant_o, busy_o
  );

  // Environment view: the requesters and the downstream bus slave.
  modport master (
    output s_sel_i, s_dat_i, s_addr_i, s_cti_i, s_stb_i, s_cyc_i, s_we_i, m_dat_i, m_ack_i,
    input  s_dat_o, s_ack_o, s_err_o, m_sel_o, m_dat_o, m_addr_o, m_cti_o, m_stb_o, m_cyc_o,
           m_we_o, grant_o, busy_o
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among M requesters. The grant is held
// for the whole cyc and a per-beat ack timeout aborts accesses to unresponsive slaves.
module wb_master_arbiter #(
  parameter int unsigned M    = 2,
  parameter int unsigned DW   = 32,
  parameter int unsigned M_Aw = 32,
  parameter int unsigned SELw = 4,
  parameter int unsigned TAGw = 3,
  parameter int unsigned TOw  = 8
) (
  input logic               clk,
  input logic               reset,
  wb_master_arbiter_if.slave bus
);

  localparam int unsigned LastW = (M > 1) ? $clog2(M) : 1;
  localparam logic [TOw-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

  state_e           state_q, state_d;
  logic [M-1:0]     grant_q, grant_d;
  logic [LastW-1:0] last_q, last_d;
  logic [TOw-1:0]   cnt_q, cnt_d;

  logic [LastW-1:0] pick;
  logic [LastW-1:0] cand;
  logic             pick_vld;
  logic             g_stb;

  logic [SELw-1:0]  sel_arr  [M];
  logic [DW-1:0]    dat_arr  [M];
  logic [M_Aw-1:0]  addr_arr [M];
  logic [TAGw-1:0]  cti_arr  [M];

  for (genvar k = 0; k < M; k++) begin : g_unpack
    assign sel_arr[k]  = bus.s_sel_i[k*SELw +: SELw];
    assign dat_arr[k]  = bus.s_dat_i[k*DW +: DW];
    assign addr_arr[k] = bus.s_addr_i[k*M_Aw +: M_Aw];
    assign cti_arr[k]  = bus.s_cti_i[k*TAGw +: TAGw];
  end

  // First requesting index after the last winner, wrapping modulo M.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= int'(M); i++) begin
      cand = LastW'((int'(last_q) + i) % int'(M));
      if (!pick_vld && bus.s_cyc_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // While a grant is held, last_q is the granted index.
  assign g_stb = bus.s_stb_i[last_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    bus.m_sel_o  = '0;
    bus.m_dat_o  = '0;
    bus.m_addr_o = '0;
    bus.m_cti_o  = '0;
    bus.m_stb_o  = 1'b0;
    bus.m_cyc_o  = 1'b0;
    bus.m_we_o   = 1'b0;
    bus.s_ack_o  = '0;
    bus.s_err_o  = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_vld) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
          state_d       = StGrant;
        end
      end

      StGrant: begin
        bus.m_sel_o          = sel_arr[last_q];
        bus.m_dat_o          = dat_arr[last_q];
        bus.m_addr_o         = addr_arr[last_q];
        bus.m_cti_o          = cti_arr[last_q];
        bus.m_stb_o          = g_stb;
        bus.m_cyc_o          = bus.s_cyc_i[last_q];
        bus.m_we_o           = bus.s_we_i[last_q];
        bus.s_ack_o[last_q]  = bus.m_ack_i;
        if (!bus.s_cyc_i[last_q]) begin
          state_d = StIdle;
          grant_d = '0;
          cnt_d   = '0;
        end else if (!g_stb || bus.m_ack_i) begin
          cnt_d = '0;
        end else if (cnt_q == CntMax) begin
          // Beat has waited the full budget: flag it and cut the bus loose.
          bus.s_err_o[last_q] = 1'b1;
          state_d             = StAbort;
          cnt_d               = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StAbort: begin
        cnt_d = '0;
        if (!bus.s_cyc_i[last_q]) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastW'(M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.busy_o  = (state_q != StIdle);
  assign bus.s_dat_o = reset ? '0 : bus.m_dat_i;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_busy_grant:   assert property (@(posedge clk) disable iff (reset)
                                   bus.busy_o == (grant_q != '0));
  a_err_pulse:    assert property (@(posedge clk) disable iff (reset)
                                   (|bus.s_err_o) |=> !(|bus.s_err_o));

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: per-cycle vector table on an M=2 instance plus
// hand-written timeout, mid-cycle reset and M=4 wrap-around sequences.
module tb_wb_master_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_master_arbiter_if #(.M(2), .DW(DW), .M_Aw(AW), .SELw(SW), .TAGw(TW)) bus2 ();
  wb_master_arbiter_if #(.M(4), .DW(DW), .M_Aw(AW), .SELw(SW), .TAGw(TW)) bus4 ();

  wb_master_arbiter #(.M(2), .DW(DW), .M_Aw(AW), .SELw(SW), .TAGw(TW), .TOw(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  wb_master_arbiter #(.M(4), .DW(DW), .M_Aw(AW), .SELw(SW), .TAGw(TW), .TOw(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic [1:0] e_grant;
    logic [1:0] e_sack;
    logic       e_mcyc;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  logic [AW-1:0] addr_tab [2] = '{32'h0000_0020, 32'h0000_0010};
  logic [DW-1:0] dat_tab  [2] = '{32'h1111_1111, 32'hDEAD_BEEF};
  logic [SW-1:0] sel_tab  [2] = '{4'h3, 4'hF};
  logic [TW-1:0] cti_tab  [2] = '{3'b111, 3'b010};
  logic          we_tab   [2] = '{1'b0, 1'b1};

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void add(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                              input logic [1:0] eg, input logic [1:0] ea, input logic ec,
                              input logic eb);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack;
    v.e_grant = eg; v.e_sack = ea; v.e_mcyc = ec; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  function automatic logic [112:0] snap2();
    return {bus2.grant_o, bus2.s_ack_o, bus2.s_err_o, bus2.m_cyc_o, bus2.m_stb_o, bus2.m_we_o,
            bus2.busy_o, bus2.m_addr_o, bus2.m_dat_o, bus2.m_sel_o, bus2.m_cti_o, bus2.s_dat_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [112:0] exp;
    logic [31:0]  mdat;
    logic         g;
    int           n;
    logic         seen;

    bus2.s_addr_i = {addr_tab[1], addr_tab[0]};
    bus2.s_dat_i  = {dat_tab[1], dat_tab[0]};
    bus2.s_sel_i  = {sel_tab[1], sel_tab[0]};
    bus2.s_cti_i  = {cti_tab[1], cti_tab[0]};
    bus2.s_we_i   = {we_tab[1], we_tab[0]};
    bus2.s_cyc_i  = '0;
    bus2.s_stb_i  = '0;
    bus2.m_ack_i  = 1'b0;
    bus2.m_dat_i  = '0;
    bus4.s_addr_i = {32'h300, 32'h200, 32'h100, 32'h000};
    bus4.s_dat_i  = '0;
    bus4.s_sel_i  = '1;
    bus4.s_cti_i  = '0;
    bus4.s_we_i   = '0;
    bus4.s_cyc_i  = '0;
    bus4.s_stb_i  = '0;
    bus4.m_ack_i  = 1'b0;
    bus4.m_dat_i  = '0;

    // Single requester 1 write, ack three cycles after stb.
    add(2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    add(2'b10, 2'b10, 0, 2'b00, 2'b00, 0, 0);
    add(2'b10, 2'b10, 0, 2'b10, 2'b00, 1, 1);
    add(2'b10, 2'b10, 0, 2'b10, 2'b00, 1, 1);
    add(2'b10, 2'b10, 0, 2'b10, 2'b00, 1, 1);
    add(2'b10, 2'b10, 1, 2'b10, 2'b10, 1, 1);
    add(2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 1);
    add(2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    // Round robin: grants 0,1,0,1 with an idle cycle between each.
    add(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 1);
    add(2'b10, 2'b10, 0, 2'b01, 2'b00, 0, 1);
    add(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b11, 1, 2'b10, 2'b10, 1, 1);
    add(2'b01, 2'b01, 0, 2'b10, 2'b00, 0, 1);
    add(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 1);
    add(2'b10, 2'b10, 0, 2'b01, 2'b00, 0, 1);
    add(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b11, 1, 2'b10, 2'b10, 1, 1);
    add(2'b01, 2'b01, 0, 2'b10, 2'b00, 0, 1);
    add(2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    // Locked: requester 0 keeps cyc through 4 acks while requester 1 waits.
    add(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 1);
    add(2'b11, 2'b11, 0, 2'b01, 2'b00, 1, 1);
    add(2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 1);
    add(2'b11, 2'b11, 0, 2'b01, 2'b00, 1, 1);
    add(2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 1);
    add(2'b11, 2'b11, 0, 2'b01, 2'b00, 1, 1);
    add(2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 1);
    add(2'b10, 2'b10, 0, 2'b01, 2'b00, 0, 1);
    add(2'b10, 2'b10, 0, 2'b00, 2'b00, 0, 0);
    add(2'b10, 2'b10, 1, 2'b10, 2'b10, 1, 1);
    add(2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 1);
    add(2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0);

    #3;
    check("reset_outputs", snap2(), '0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      mdat         = 32'hCAFE_0000 + 32'(i);
      bus2.s_cyc_i = vecs[i].cyc;
      bus2.s_stb_i = vecs[i].stb;
      bus2.m_ack_i = vecs[i].ack;
      bus2.m_dat_i = mdat;
      g            = vecs[i].e_grant[1];
      exp = {vecs[i].e_grant, vecs[i].e_sack, 2'b00, vecs[i].e_mcyc,
             vecs[i].e_busy ? vecs[i].stb[g] : 1'b0,
             vecs[i].e_busy ? we_tab[g] : 1'b0,
             vecs[i].e_busy,
             vecs[i].e_busy ? addr_tab[g] : 32'h0,
             vecs[i].e_busy ? dat_tab[g] : 32'h0,
             vecs[i].e_busy ? sel_tab[g] : 4'h0,
             vecs[i].e_busy ? cti_tab[g] : 3'h0,
             mdat};
      @(negedge clk);
      check($sformatf("vec%0d", i), snap2(), exp);
      @(posedge clk);
      #1;
    end
    bus2.m_ack_i = 1'b0;

    // Timeout: requester 1 strobes a slave that never acks.
    bus2.s_cyc_i = 2'b10;
    bus2.s_stb_i = 2'b10;
    @(posedge clk);
    #1;
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus2.s_err_o != 2'b00) begin
        seen = 1'b1;
      end else begin
        if (bus2.m_stb_o) n++;
        @(posedge clk);
        #1;
      end
    end
    check("timeout_seen", 256'(seen), 256'(1));
    check("timeout_cycles", 256'(n), 256'(15));
    check("err_cycle", {bus2.s_err_o, bus2.m_cyc_o, bus2.grant_o}, {2'b10, 1'b1, 2'b10});
    @(posedge clk);
    #1;
    check("abort_outputs", {bus2.m_cyc_o, bus2.m_stb_o, bus2.m_we_o, bus2.s_err_o,
                            bus2.s_ack_o, bus2.busy_o, bus2.grant_o},
          {3'b000, 2'b00, 2'b00, 1'b1, 2'b10});
    bus2.m_ack_i = 1'b1;
    #1;
    check("late_ack_abort", bus2.s_ack_o, 2'b00);
    @(posedge clk);
    #1;
    check("abort_hold", {bus2.busy_o, bus2.grant_o}, {1'b1, 2'b10});
    bus2.s_cyc_i = 2'b00;
    bus2.s_stb_i = 2'b00;
    @(posedge clk);
    #1;
    check("abort_release", {bus2.busy_o, bus2.grant_o, bus2.s_ack_o, bus2.m_cyc_o},
          {1'b0, 2'b00, 2'b00, 1'b0});
    bus2.m_ack_i = 1'b0;

    // Reset in the middle of a granted, strobing cycle.
    bus2.s_cyc_i = 2'b01;
    bus2.s_stb_i = 2'b01;
    @(posedge clk);
    #1;
    check("pre_reset_grant", {bus2.grant_o, bus2.m_stb_o}, {2'b01, 1'b1});
    bus2.m_ack_i = 1'b1;
    bus2.m_dat_i = 32'h5555_AAAA;
    #2 reset = 1'b1;
    #1;
    check("reset_async", snap2(), '0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus2.m_ack_i = 1'b0;
    bus2.s_cyc_i = 2'b11;
    bus2.s_stb_i = 2'b11;
    @(posedge clk);
    #1;
    check("post_reset_prio", bus2.grant_o, 2'b01);
    bus2.s_cyc_i = 2'b00;
    bus2.s_stb_i = 2'b00;
    @(posedge clk);
    #1;

    // M=4 pointer wrap, starting from the reset pointer of 3.
    bus4.s_cyc_i = 4'b1010;
    bus4.s_stb_i = 4'b1010;
    @(posedge clk);
    #1;
    check("m4_grant1", {bus4.grant_o, bus4.m_addr_o}, {4'b0010, 32'h100});
    bus4.s_cyc_i = 4'b1000;
    bus4.s_stb_i = 4'b1000;
    @(posedge clk);
    #1;
    check("m4_release1", bus4.grant_o, 4'b0000);
    @(posedge clk);
    #1;
    check("m4_grant3", {bus4.grant_o, bus4.m_addr_o}, {4'b1000, 32'h300});
    bus4.s_cyc_i = 4'b0011;
    bus4.s_stb_i = 4'b0011;
    @(posedge clk);
    #1;
    check("m4_release3", bus4.grant_o, 4'b0000);
    @(posedge clk);
    #1;
    check("m4_wrap0", {bus4.grant_o, bus4.m_addr_o}, {4'b0001, 32'h000});
    bus4.s_cyc_i = 4'b0000;
    bus4.s_stb_i = 4'b0000;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
